bus_arbiter: RTL and testbench

- Arbitrates the shared 16-bit address bus and 8-bit data bus between up to NUM_REQ masters, e.g. the CPU fetch/execute path, a DMA engine and port logic.
- Grants one master at a time using round-robin priority and routes that master's address, write data and strobes to the RAM/IO slave side.
- Enforces a maximum burst length unless the owner asserts lock.
- Sits between the masters and the RAM/memory-mapped ports.

---
 rtl/bus_arbiter.sv | 138 +++++++++++++
 tb/tb_bus_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared address/data bus: one master owns the slave side
// at a time, with a burst limit that only the owner's lock can override.
module bus_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             lock,
    input  logic [NUM_REQ-1:0]             we_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             ack,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic                           mem_we,
    output logic                           mem_oe,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           busy,
    output logic [2:0]                     owner
);

    localparam int unsigned IDX_W      = 3;
    localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [7:0]  BEAT_SAT   = 8'hFF;

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last;
    logic [7:0]             beat_cnt;

    logic [7:0]             req_pad;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       win;
    logic                   win_valid;
    logic [NUM_REQ-1:0]     win_oh;

    logic                   sel_req;
    logic                   sel_lock;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   own;

    // Round-robin pick: first requester after the previous owner.
    always_comb begin
        req_pad   = 8'(req);
        cand      = '0;
        win       = '0;
        win_valid = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IDX_W'((int'(last) + k) % int'(NUM_REQ));
            if (!win_valid && req_pad[cand]) begin
                win       = cand;
                win_valid = 1'b1;
            end
        end
        win_oh = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            win_oh[i] = (win == IDX_W'(i));
        end
    end

    // Owner's request lines steered onto the slave side.
    always_comb begin
        sel_req   = 1'b0;
        sel_lock  = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (owner == IDX_W'(i)) begin
                sel_req   = req[i];
                sel_lock  = lock[i];
                sel_we    = we_in[i];
                sel_addr  = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign own       = (state == S_OWN);
    assign mem_we    = own & sel_req & sel_we;
    assign mem_oe    = own & sel_req & ~sel_we;
    assign mem_addr  = own ? sel_addr : '0;
    assign mem_wdata = own ? sel_wdata : '0;
    assign ack       = gnt & {NUM_REQ{own & sel_req}};
    assign rdata     = mem_oe ? mem_rdata : '0;
    assign busy      = |gnt;

    // Grant/ownership state; release forces one idle cycle before the next owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            gnt      <= '0;
            owner    <= '0;
            last     <= IDX_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        state    <= S_OWN;
                        gnt      <= win_oh;
                        owner    <= win;
                        beat_cnt <= '0;
                    end
                end
                S_OWN: begin
                    if (sel_req && beat_cnt != BEAT_SAT) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    if (!sel_req || (!sel_lock && beat_cnt >= BURST_LAST)) begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        last  <= owner;
                        owner <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_ack_subset: assert property (@(posedge clk) disable iff (reset) (ack & ~gnt) == '0);
    a_we_oe_excl: assert property (@(posedge clk) disable iff (reset) !(mem_we && mem_oe));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table for the basic,
// write, contention and zero-transfer cases, then hand sequences for burst/lock/reset.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, lock, we_in;
    logic [63:0] addr_in;
    logic [31:0] wdata_in;
    logic [3:0]  gnt, ack;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_we, mem_oe, busy;
    logic [2:0]  owner;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we_in(we_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .ack(ack), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        mwe;
        logic        moe;
        logic [15:0] maddr;
        logic [7:0]  mwdata;
        logic [7:0]  rdata;
        logic        busy;
        logic [2:0]  owner;
    } vec_t;

    vec_t vt[29];

    function automatic vec_t v(logic [3:0] r, logic [3:0] w, logic [3:0] g, logic [3:0] a,
                               logic mw, logic mo, logic [15:0] ma, logic [7:0] md,
                               logic [7:0] rd, logic b, logic [2:0] o);
        vec_t x;
        x.req = r; x.we = w; x.gnt = g; x.ack = a; x.mwe = mw; x.moe = mo;
        x.maddr = ma; x.mwdata = md; x.rdata = rd; x.busy = b; x.owner = o;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack3;
        int n_ack0;

        // master i: addr / wdata
        addr_in   = {16'h0083, 16'h0040, 16'h0021, 16'h0012};
        wdata_in  = {8'h44, 8'h3C, 8'h22, 8'h11};
        mem_rdata = 8'hA5;
        req = '0; lock = '0; we_in = '0;
        reset = 1'b1;

        vt[0]  = v(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[1]  = v(4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 1, 16'h0012, 8'h11, 8'hA5, 1, 0);
        vt[2]  = v(4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 1, 16'h0012, 8'h11, 8'hA5, 1, 0);
        vt[3]  = v(4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 1, 16'h0012, 8'h11, 8'hA5, 1, 0);
        vt[4]  = v(4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 16'h0012, 8'h11, 8'h00, 1, 0);
        vt[5]  = v(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[6]  = v(4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[7]  = v(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 0, 16'h0040, 8'h3C, 8'h00, 1, 2);
        vt[8]  = v(4'b0000, 4'b0100, 4'b0100, 4'b0000, 0, 0, 16'h0040, 8'h3C, 8'h00, 1, 2);
        vt[9]  = v(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[10] = v(4'b0110, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[11] = v(4'b0110, 4'b0000, 4'b0010, 4'b0010, 0, 1, 16'h0021, 8'h22, 8'hA5, 1, 1);
        vt[12] = v(4'b0110, 4'b0000, 4'b0010, 4'b0010, 0, 1, 16'h0021, 8'h22, 8'hA5, 1, 1);
        vt[13] = v(4'b0100, 4'b0000, 4'b0010, 4'b0000, 0, 0, 16'h0021, 8'h22, 8'h00, 1, 1);
        vt[14] = v(4'b0110, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[15] = v(4'b0110, 4'b0000, 4'b0100, 4'b0100, 0, 1, 16'h0040, 8'h3C, 8'hA5, 1, 2);
        vt[16] = v(4'b0110, 4'b0000, 4'b0100, 4'b0100, 0, 1, 16'h0040, 8'h3C, 8'hA5, 1, 2);
        vt[17] = v(4'b0010, 4'b0000, 4'b0100, 4'b0000, 0, 0, 16'h0040, 8'h3C, 8'h00, 1, 2);
        vt[18] = v(4'b0110, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[19] = v(4'b0110, 4'b0000, 4'b0010, 4'b0010, 0, 1, 16'h0021, 8'h22, 8'hA5, 1, 1);
        vt[20] = v(4'b0110, 4'b0000, 4'b0010, 4'b0010, 0, 1, 16'h0021, 8'h22, 8'hA5, 1, 1);
        vt[21] = v(4'b0100, 4'b0000, 4'b0010, 4'b0000, 0, 0, 16'h0021, 8'h22, 8'h00, 1, 1);
        vt[22] = v(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[23] = v(4'b0100, 4'b0000, 4'b0100, 4'b0100, 0, 1, 16'h0040, 8'h3C, 8'hA5, 1, 2);
        vt[24] = v(4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 0, 16'h0040, 8'h3C, 8'h00, 1, 2);
        vt[25] = v(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[26] = v(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);
        vt[27] = v(4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 16'h0012, 8'h11, 8'h00, 1, 0);
        vt[28] = v(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0);

        tick();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_owner", 32'(owner), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            req   = vt[i].req;
            we_in = vt[i].we;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(vt[i].ack));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].mwe));
            chk($sformatf("v%0d_mem_oe", i), 32'(mem_oe), 32'(vt[i].moe));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].maddr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vt[i].mwdata));
            chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vt[i].rdata));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vt[i].owner));
            tick();
        end

        // Burst limit: master 3 (next after last owner 0) gets 8 beats, idle, then master 0.
        req = 4'b1001; lock = 4'b0000; we_in = 4'b0000;
        n_ack3 = 0; n_ack0 = 0;
        tick();
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (ack[3]) n_ack3++;
            if (c <= 8) chk($sformatf("burst_c%0d_gnt", c), 32'(gnt), 32'h8);
            if (c == 9) chk("burst_idle_gnt", 32'(gnt), 32'h0);
            if (c == 10) chk("burst_next_gnt", 32'(gnt), 32'h1);
            if (c == 10) chk("burst_next_ack", 32'(ack), 32'h1);
            tick();
        end
        chk("burst_ack3_count", 32'(n_ack3), 32'd8);
        req = 4'b0000;
        tick();
        tick();

        // Lock: master 3 holds for 20 beats, master 0 starved; lock drop releases after one more beat.
        req = 4'b1001; lock = 4'b1000;
        n_ack3 = 0; n_ack0 = 0;
        tick();
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (ack[3]) n_ack3++;
            if (ack[0]) n_ack0++;
            chk($sformatf("lock_c%0d_gnt", c), 32'(gnt), 32'h8);
            tick();
        end
        chk("lock_ack3_count", 32'(n_ack3), 32'd20);
        chk("lock_ack0_count", 32'(n_ack0), 32'd0);
        lock = 4'b0000;
        #1;
        chk("lock_final_ack", 32'(ack), 32'h8);
        tick();
        chk("lock_release_gnt", 32'(gnt), 32'h0);
        tick();
        chk("lock_next_gnt", 32'(gnt), 32'h1);
        chk("lock_next_owner", 32'(owner), 32'd0);
        req = 4'b0000;
        tick();
        tick();

        // Reset during beat 4 of a write burst; outputs clear without a clock edge.
        req = 4'b0001; we_in = 4'b0001;
        tick();
        tick(); tick(); tick();
        #1;
        chk("rst_pre_mem_we", 32'(mem_we), 32'h1);
        chk("rst_pre_ack", 32'(ack), 32'h1);
        #1;
        reset = 1'b1;
        req = 4'b0011;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_oe", 32'(mem_oe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        #2;
        reset = 1'b0;
        tick();
        chk("rst_regrant_gnt", 32'(gnt), 32'h1);
        chk("rst_regrant_owner", 32'(owner), 32'd0);
        req = 4'b0000;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
